// File: rtl/led_pkg.sv
// Shared types and default timing for the LED pulse stretcher.
// LED_ACTIVE_LOW_EN selects an active-low LED pin; see led_level().
package led_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    GAP  = 2'd2
  } led_state_t;

  localparam int unsigned DEF_CLK_HZ     = 27_000_000;
  localparam int unsigned FLASH_DIV      = 10;
  localparam int unsigned DEF_ON_CYCLES  = DEF_CLK_HZ / FLASH_DIV;
  localparam int unsigned DEF_OFF_CYCLES = DEF_CLK_HZ / FLASH_DIV;
  localparam int          DEF_CNT_W      = 22;
  localparam int          DEF_PEND_W     = 4;

  // Maps the logical "lit" flag onto the pin level seen by the board.
  function automatic logic led_level(input logic lit);
`ifdef LED_ACTIVE_LOW_EN
    return ~lit;
`else
    return lit;
`endif
  endfunction

endpackage

// File: rtl/sat_event_counter.sv
// Saturating up/down event counter with a sticky overflow flag.
// A simultaneous inc and dec leaves the count unchanged.
module sat_event_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] count,
  output logic         overflow
);

  localparam logic [W-1:0] MAX  = {W{1'b1}};
  localparam logic [W-1:0] ZERO = {W{1'b0}};
  localparam logic [W-1:0] ONE  = W'(1);

  // Count update; an increment at MAX is dropped and latched as overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      count    <= ZERO;
      overflow <= 1'b0;
    end else if (inc && !dec) begin
      if (count == MAX) begin
        overflow <= 1'b1;
      end else begin
        count <= count + ONE;
      end
    end else if (dec && !inc && (count != ZERO)) begin
      count <= count - ONE;
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/led_pulse_stretcher.sv
// Turns single-cycle events into visible LED flashes, queuing events that
// arrive mid-flash. Pin polarity follows LED_ACTIVE_LOW_EN (see led_pkg).
module led_pulse_stretcher
  import led_pkg::*;
#(
  parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
  parameter int unsigned ON_CYCLES  = (CLK_HZ == DEF_CLK_HZ) ? DEF_ON_CYCLES  : CLK_HZ / FLASH_DIV,
  parameter int unsigned OFF_CYCLES = (CLK_HZ == DEF_CLK_HZ) ? DEF_OFF_CYCLES : CLK_HZ / FLASH_DIV,
  parameter int          CNT_W      = DEF_CNT_W,
  parameter int          PEND_W     = DEF_PEND_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_event,
  output logic              o_led,
  output logic              o_busy,
  output logic [PEND_W-1:0] o_pending,
  output logic              o_overflow
);

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] T_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] T_ONE    = CNT_W'(1);

  led_state_t       state;
  logic [CNT_W-1:0] timer;
  logic             have_queued;
  logic             start;
  logic             deq;
  logic             enq;

  // A flash may start from IDLE or on the final GAP cycle; the queue is
  // drained before a fresh event, and a fresh event not consumed is queued.
  always_comb begin
    have_queued = (o_pending != {PEND_W{1'b0}});
    start       = (i_event | have_queued) &
                  ((state == IDLE) | ((state == GAP) & (timer == OFF_LAST)));
    deq         = start & have_queued;
    enq         = i_event & ~(start & ~have_queued);
  end

  sat_event_counter #(
    .W (PEND_W)
  ) u_pending (
    .clk      (i_clk),
    .rst      (i_rst),
    .inc      (enq),
    .dec      (deq),
    .count    (o_pending),
    .overflow (o_overflow)
  );

  // Flash sequencer with registered LED and busy outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= IDLE;
      timer  <= T_ZERO;
      o_led  <= led_level(1'b0);
      o_busy <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= ON;
            timer  <= T_ZERO;
            o_led  <= led_level(1'b1);
            o_busy <= 1'b1;
          end else begin
            state  <= IDLE;
            timer  <= T_ZERO;
            o_led  <= led_level(1'b0);
            o_busy <= 1'b0;
          end
        end
        ON: begin
          if (timer == ON_LAST) begin
            state <= GAP;
            timer <= T_ZERO;
            o_led <= led_level(1'b0);
          end else begin
            timer <= timer + T_ONE;
            o_led <= led_level(1'b1);
          end
          o_busy <= 1'b1;
        end
        GAP: begin
          if (timer != OFF_LAST) begin
            timer  <= timer + T_ONE;
            o_led  <= led_level(1'b0);
            o_busy <= 1'b1;
          end else if (start) begin
            state  <= ON;
            timer  <= T_ZERO;
            o_led  <= led_level(1'b1);
            o_busy <= 1'b1;
          end else begin
            state  <= IDLE;
            timer  <= T_ZERO;
            o_led  <= led_level(1'b0);
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          timer  <= T_ZERO;
          o_led  <= led_level(1'b0);
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_led_pulse_stretcher.sv
// Scoreboard bench for led_pulse_stretcher (ON=4, OFF=3, PEND_W=2).
// Honours LED_ACTIVE_LOW_EN for the expected pin level.
module tb_led_pulse_stretcher;

  localparam int ON_C   = 4;
  localparam int OFF_C  = 3;
  localparam int PEND_W = 2;
  localparam int Q_MAX  = 3;
`ifdef LED_ACTIVE_LOW_EN
  localparam logic LIT  = 1'b0;
`else
  localparam logic LIT  = 1'b1;
`endif
  localparam logic DARK = ~LIT;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ev  = 1'b0;
  logic              led;
  logic              busy;
  logic [PEND_W-1:0] pending;
  logic              overflow;

  led_pulse_stretcher #(
    .ON_CYCLES  (ON_C),
    .OFF_CYCLES (OFF_C),
    .CNT_W      (22),
    .PEND_W     (PEND_W)
  ) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_event    (ev),
    .o_led      (led),
    .o_busy     (busy),
    .o_pending  (pending),
    .o_overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic led;
    logic busy;
    int   pend;
    logic ovf;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  // Reference model: phase plus cycles remaining in that phase.
  int   m_phase;  // 0 idle, 1 on, 2 gap
  int   m_rem;
  int   m_q;
  logic m_ovf;

  task automatic check_eq(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic m_enqueue();
    if (m_q == Q_MAX) m_ovf = 1'b1;
    else m_q++;
  endtask

  task automatic m_take(input logic e);
    if (m_q > 0) begin
      m_q--;
      if (e) m_enqueue();
    end
    m_phase = 1;
    m_rem   = ON_C;
  endtask

  task automatic model_step(input logic e, input logic r);
    if (r) begin
      m_phase = 0; m_rem = 0; m_q = 0; m_ovf = 1'b0;
    end else if (m_phase == 0) begin
      if (e || m_q > 0) m_take(e);
    end else if (m_phase == 1) begin
      if (e) m_enqueue();
      m_rem--;
      if (m_rem == 0) begin
        m_phase = 2;
        m_rem   = OFF_C;
      end
    end else begin
      m_rem--;
      if (m_rem == 0) begin
        if (e || m_q > 0) m_take(e);
        else m_phase = 0;
      end else if (e) begin
        m_enqueue();
      end
    end
  endtask

  // Drive one cycle, push the model's prediction, compare after the edge.
  task automatic step(input logic e, input logic r, input string name, input int cyc);
    exp_t x;
    @(negedge clk);
    ev  = e;
    rst = r;
    model_step(e, r);
    x.led  = (m_phase == 1) ? LIT : DARK;
    x.busy = (m_phase != 0);
    x.pend = m_q;
    x.ovf  = m_ovf;
    sb.push_back(x);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    check_eq($sformatf("%s c%0d led", name, cyc), int'(led), int'(x.led));
    check_eq($sformatf("%s c%0d busy", name, cyc), int'(busy), int'(x.busy));
    check_eq($sformatf("%s c%0d pend", name, cyc), int'(pending), x.pend);
    check_eq($sformatf("%s c%0d ovf", name, cyc), int'(overflow), int'(x.ovf));
  endtask

  // Cycles 0-1 are reset; o = observed cycle index after each step.
  task automatic run(input int id, input string name, input logic [63:0] mask,
                     input int ncyc, input int rst_at);
    int max_p = 0;
    for (int c = 0; c < ncyc; c++) begin
      int o;
      step(mask[c], (c < 2) || (c == rst_at), name, c + 1);
      o = c + 1;
      if (int'(pending) > max_p) max_p = int'(pending);
      if (o == 2) begin
        check_eq({name, " reset led"}, int'(led), int'(DARK));
        check_eq({name, " reset busy"}, int'(busy), 0);
        check_eq({name, " reset pend"}, int'(pending), 0);
        check_eq({name, " reset ovf"}, int'(overflow), 0);
      end
      case (id)
        1: begin
          if (o == 11 || o == 14) check_eq({name, " lit"}, int'(led), int'(LIT));
          if (o == 15 || o == 17) check_eq({name, " gap dark"}, int'(led), int'(DARK));
          if (o == 17) check_eq({name, " busy in gap"}, int'(busy), 1);
          if (o == 18) check_eq({name, " busy drop"}, int'(busy), 0);
        end
        2: begin
          if (o == 18 || o == 25) check_eq({name, " flash start"}, int'(led), int'(LIT));
          if (o == 24) check_eq({name, " pend pre"}, int'(pending), 1);
          if (o == 25) check_eq({name, " pend drained"}, int'(pending), 0);
        end
        4: begin
          if (o == 18) check_eq({name, " pend hold"}, int'(pending), 1);
          if (o == 18) check_eq({name, " led restart"}, int'(led), int'(LIT));
        end
        5: begin
          if (o == 13) check_eq({name, " pend before rst"}, int'(pending), 2);
          if (o == 14) begin
            check_eq({name, " rst led"}, int'(led), int'(DARK));
            check_eq({name, " rst busy"}, int'(busy), 0);
            check_eq({name, " rst pend"}, int'(pending), 0);
            check_eq({name, " rst ovf"}, int'(overflow), 0);
          end
          if (o > 14) check_eq({name, " no flash"}, int'(led), int'(DARK));
        end
        default: ;
      endcase
    end
    if (id == 2) check_eq({name, " pend peak"}, max_p, 2);
    if (id == 3) begin
      check_eq({name, " pend peak"}, max_p, Q_MAX);
      check_eq({name, " ovf sticky"}, int'(overflow), 1);
      check_eq({name, " drained"}, int'(pending), 0);
      check_eq({name, " idle"}, int'(busy), 0);
    end
  endtask

  initial begin
    m_phase = 0; m_rem = 0; m_q = 0; m_ovf = 1'b0;
    run(1, "single",   64'd1 << 10, 30, -1);
    run(2, "three",    (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 13), 40, -1);
    run(3, "held",     64'hFF << 10, 55, -1);
    run(4, "enq_deq",  (64'd1 << 10) | (64'd1 << 12) | (64'd1 << 17), 40, -1);
    run(5, "mid_rst",  (64'd1 << 10) | (64'd1 << 11) | (64'd1 << 12) | (64'd1 << 13), 40, 13);
    check_eq("scoreboard empty", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/led_pulse_stretcher.md
# led_pulse_stretcher

Output-side counterpart to the button debouncer: where the debouncer turns slow, noisy human input into clean single-cycle-safe levels, this block turns single-cycle internal events into LED flashes a human can see and count. Each accepted event produces exactly one LED on-pulse of fixed length followed by a fixed minimum off gap. Events arriving while a flash is in progress are queued in a saturating counter and replayed back-to-back. It sits between core logic (retire strobes, debounced-button edges, error flags) and board LED pins.

## Interface
- CLK_HZ, 27_000_000, board clock frequency (documentation only; defaults derive from it)
- ON_CYCLES, 2_700_000, LED on-time per flash in clock cycles (100 ms at 27 MHz); must be ≥ 1
- OFF_CYCLES, 2_700_000, minimum LED off-time between flashes in cycles; must be ≥ 1
- CNT_W, 22, timer width; 2^CNT_W > max(ON_CYCLES, OFF_CYCLES)
- PEND_W, 4, pending-event counter width; saturates at 2^PEND_W − 1
- i_clk  input  1  single clock, all logic on rising edge
- i_rst  input  1  synchronous, active-high reset
- i_event  input  1  event request; every cycle it is high counts as one event
- o_led  output  1  LED drive (registered)
- o_busy  output  1  high in ON or GAP
- o_pending  output  PEND_W  queued events not yet started
- o_overflow  output  1  sticky: an event was dropped at saturation

## Operation
- Reset values: state IDLE, timer 0, o_pending 0, o_overflow 0, o_busy 0, o_led at inactive level.
- States: IDLE, ON, GAP.
- IDLE: if i_event or o_pending ≠ 0 → ON, timer cleared; a queued event is consumed first (i_event then increments the queue).
- ON: o_led active; timer counts 0..ON_CYCLES−1; at ON_CYCLES−1 → GAP, timer cleared.
- GAP: o_led inactive; timer counts 0..OFF_CYCLES−1; at OFF_CYCLES−1: if o_pending ≠ 0 or i_event → ON directly (no IDLE cycle), consuming one event; else → IDLE.
- i_event while busy and not being consumed → o_pending + 1.
- Simultaneous enqueue and dequeue in one cycle → o_pending unchanged.
- Saturation: o_pending at max and enqueue without dequeue → o_pending holds max, o_overflow set; o_overflow clears only on reset.
- Timer is CNT_W-bit unsigned; compare for equality against parameter − 1, never wraps.

## Timing
- i_event high at cycle N in IDLE → o_led active from N+1 for exactly ON_CYCLES cycles.
- Back-to-back flash period exactly ON_CYCLES + OFF_CYCLES; no idle cycle inserted.
- o_busy asserts same cycle as o_led first goes active; deasserts the cycle state returns to IDLE.
- o_pending/o_overflow update one cycle after the causing i_event.
- i_rst mid-flash: next cycle all outputs at reset values, queue discarded, i_event in the reset cycle ignored.

## Configuration
- LED_ACTIVE_LOW_EN defined: o_led driven low when lit, high when dark; reset value 1 (Tang Nano-style LEDs).
- Undefined: o_led high when lit, low when dark; reset value 0.
- No other behaviour changes.

## Structure
- Shared package led_pkg: state enum (IDLE, ON, GAP), default ON_CYCLES/OFF_CYCLES constants derived from 27 MHz.
- One sub-module: sat_event_counter (PEND_W-bit up/down counter with inc, dec, saturation and sticky overflow).

## Test plan
Bench parameters: ON_CYCLES=4, OFF_CYCLES=3, PEND_W=2.
- Reset then single i_event pulse at cycle 10 → o_led active cycles 11–14, inactive 15–17, o_busy low from 18, o_pending 0.
- Three i_event pulses at cycles 10, 12, 13 → flashes start at 11, 18, 25; o_pending peaks at 2, reaches 0 at 25.
- i_event held high 8 cycles from IDLE → first flash starts, o_pending saturates at 3, o_overflow = 1 and stays 1 after queue drains.
- Enqueue and dequeue same cycle (i_event high on last GAP cycle with o_pending=1) → next flash starts, o_pending stays 1.
- i_rst asserted in cycle 2 of ON with o_pending=2 → next cycle o_led inactive, o_busy 0, o_pending 0, o_overflow 0; no further flashes.
- Rebuild with LED_ACTIVE_LOW_EN → same sequences with o_led inverted; o_led = 1 during reset.
